// File: rtl/mem_arb_pkg.sv
// Shared encodings for the memory-port arbiter: FSM states, owner sides and word-index width.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_BURST  = 2'd1,
    ST_FINISH = 2'd2
  } state_t;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_t;

  localparam int LINE_WORDS_DFLT = 4;

  function automatic int idx_w(input int words);
    return (words > 1) ? $clog2(words) : 1;
  endfunction

  localparam int IDX_W = idx_w(LINE_WORDS_DFLT);

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational burst winner select; define MEM_ARB_ROUND_ROBIN_EN to alternate on contention
// (default: D-side fixed priority). A lone requester always wins.
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic   i_req,
  input  logic   d_req,
  input  owner_t last_owner,
  output owner_t winner
);

  always_comb begin
    winner = OWN_I;
    if (i_req && d_req) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
      winner = (last_owner == OWN_I) ? OWN_D : OWN_I;
`else
      winner = OWN_D;
`endif
    end else if (d_req) begin
      winner = OWN_D;
    end
  end

`ifndef MEM_ARB_ROUND_ROBIN_EN
  logic unused_last_owner;
  assign unused_last_owner = last_owner;
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Grants the shared memory port one line burst at a time (IDLE -> BURST -> FINISH); burst starts
// the cycle after req is seen in IDLE and each word waits for mem_ack. Macro: MEM_ARB_ROUND_ROBIN_EN.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int LINE_WORDS = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              i_req,
  input  logic                              i_we,
  input  logic [ADDR_W-1:0]                 i_addr,
  input  logic [DATA_W-1:0]                 i_wdata,
  output logic                              i_rvalid,
  output logic                              i_done,
  input  logic                              d_req,
  input  logic                              d_we,
  input  logic [ADDR_W-1:0]                 d_addr,
  input  logic [DATA_W-1:0]                 d_wdata,
  output logic                              d_rvalid,
  output logic                              d_done,
  output logic [DATA_W-1:0]                 rdata,
  output logic [idx_w(LINE_WORDS)-1:0]      word_idx,
  output logic                              mem_cs,
  output logic                              mem_we,
  output logic [ADDR_W-1:0]                 mem_addr,
  output logic [DATA_W-1:0]                 mem_wdata,
  input  logic [DATA_W-1:0]                 mem_rdata,
  input  logic                              mem_ack,
  output logic                              arb_busy
);

  localparam int IW      = idx_w(LINE_WORDS);
  localparam int BYTE_SH = $clog2(DATA_W / 8);

  state_t          state;
  owner_t          owner;
  owner_t          last_owner;
  owner_t          winner;
  logic [IW-1:0]   cnt;

  mem_arb_pick u_pick (
    .i_req      (i_req),
    .d_req      (d_req),
    .last_owner (last_owner),
    .winner     (winner)
  );

  // cnt holds at LINE_WORDS-1 on the final ack so it only returns to 0 via IDLE
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      owner      <= OWN_D;
      last_owner <= OWN_I;
      cnt        <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (i_req || d_req) begin
            owner <= winner;
            cnt   <= '0;
            state <= ST_BURST;
          end
        end
        ST_BURST: begin
          if (mem_ack) begin
            if (cnt == IW'(LINE_WORDS - 1)) state <= ST_FINISH;
            else                            cnt   <= cnt + 1'b1;
          end
        end
        ST_FINISH: begin
          last_owner <= owner;
          state      <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  logic              in_burst;
  logic              own_d;
  logic              cur_we;
  logic              rd_ack;
  logic [ADDR_W-1:0] base;
  logic [DATA_W-1:0] cur_wdata;

  assign in_burst  = (state == ST_BURST);
  assign own_d     = (owner == OWN_D);
  assign cur_we    = own_d ? d_we : i_we;
  assign base      = own_d ? d_addr : i_addr;
  assign cur_wdata = own_d ? d_wdata : i_wdata;
  assign rd_ack    = in_burst && mem_ack && !cur_we;

  assign mem_cs    = in_burst;
  assign mem_we    = in_burst && cur_we;
  assign mem_addr  = in_burst ? base + (ADDR_W'(cnt) << BYTE_SH) : '0;
  assign mem_wdata = in_burst ? cur_wdata : '0;
  assign word_idx  = in_burst ? cnt : '0;
  assign rdata     = rd_ack ? mem_rdata : '0;
  assign i_rvalid  = rd_ack && !own_d;
  assign d_rvalid  = rd_ack && own_d;
  assign i_done    = (state == ST_FINISH) && !own_d;
  assign d_done    = (state == ST_FINISH) && own_d;
  assign arb_busy  = (state != ST_IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a word scoreboard and a small memory model.
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  localparam logic [31:0] RD_KEY = 32'h5A5A_0000;

  logic             clk = 1'b0;
  logic             rst;
  logic             i_req, i_we, d_req, d_we;
  logic [31:0]      i_addr, d_addr, i_wdata, d_wdata;
  logic             i_rvalid, i_done, d_rvalid, d_done;
  logic [31:0]      rdata;
  logic [IDX_W-1:0] word_idx;
  logic             mem_cs, mem_we, mem_ack, arb_busy;
  logic [31:0]      mem_addr, mem_wdata, mem_rdata;

  mem_port_arbiter dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_we(i_we), .i_addr(i_addr), .i_wdata(i_wdata),
    .i_rvalid(i_rvalid), .i_done(i_done),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rvalid(d_rvalid), .d_done(d_done),
    .rdata(rdata), .word_idx(word_idx),
    .mem_cs(mem_cs), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .arb_busy(arb_busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    logic             side;   // 0 = I, 1 = D
    logic             we;
    logic [31:0]      addr;
    logic [IDX_W-1:0] idx;
  } exp_t;

  exp_t exp_q[$];
  logic done_q[$];

  int compared = 0, mismatched = 0;
  int wait_n = 0;
  logic force_ack = 1'b0;
  int done_seen = 0, done_cyc = 0, busy_cnt = 0, first_cs_cyc = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push_burst(input logic side, input logic we, input logic [31:0] base);
    for (int w = 0; w < LINE_WORDS_DFLT; w++) begin
      exp_t e;
      e.side = side; e.we = we; e.addr = base + 32'(4 * w); e.idx = IDX_W'(w);
      exp_q.push_back(e);
    end
    done_q.push_back(side);
  endtask

  // Memory model plus scoreboard; runs every negedge, checks 1 time unit later
  task automatic monitor();
    int   wcnt = 0, held = 0;
    logic prev_cs = 1'b0;
    forever begin
      @(negedge clk);
      if (mem_cs) begin
        mem_ack = (wcnt == wait_n);
        wcnt    = mem_ack ? 0 : wcnt + 1;
      end else begin
        mem_ack = force_ack;
        wcnt    = 0;
      end
      mem_rdata = mem_addr ^ RD_KEY;
      i_wdata   = 32'h50 + 32'(word_idx);
      d_wdata   = 32'hA0 + 32'(word_idx);
      #1;
      if (arb_busy) busy_cnt++;
      if (mem_cs && !prev_cs) first_cs_cyc = cyc;
      prev_cs = mem_cs;
      if (mem_cs) begin
        chk("cs_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          exp_t e = exp_q[0];
          held++;
          chk("mem_addr", mem_addr, e.addr);
          chk("mem_we", 32'(mem_we), 32'(e.we));
          chk("word_idx", 32'(word_idx), 32'(e.idx));
          chk("mem_wdata", mem_wdata, (e.side ? 32'hA0 : 32'h50) + 32'(e.idx));
          if (mem_ack) begin
            chk("i_rvalid", 32'(i_rvalid), 32'(!e.we && !e.side));
            chk("d_rvalid", 32'(d_rvalid), 32'(!e.we && e.side));
            if (!e.we) chk("rdata", rdata, e.addr ^ RD_KEY);
            chk("word_hold", 32'(held), 32'(wait_n + 1));
            held = 0;
            void'(exp_q.pop_front());
          end else begin
            chk("rvalid_wait", 32'({i_rvalid, d_rvalid}), 32'd0);
          end
        end
      end else begin
        held = 0;
        chk("rvalid_idle", 32'({i_rvalid, d_rvalid}), 32'd0);
      end
      if (i_done || d_done) begin
        chk("done_expected", 32'(done_q.size() != 0), 32'd1);
        if (done_q.size() != 0) begin
          chk("done_side", 32'({i_done, d_done}), done_q[0] ? 32'd1 : 32'd2);
          void'(done_q.pop_front());
        end
        done_seen++;
        done_cyc = cyc;
      end
    end
  endtask

  task automatic wait_done(input int target);
    int n = 0;
    while (done_seen < target && n < 300) begin
      @(negedge clk); #2;
      n++;
    end
    chk("done_timeout", 32'(done_seen), 32'(target));
  endtask

  task automatic drop_reqs();
    @(posedge clk); #1;
    i_req = 1'b0; d_req = 1'b0;
  endtask

  task automatic start(input logic side, input logic we, input logic [31:0] base, output int t0);
    @(posedge clk); #1;
    if (side) begin d_we = we; d_addr = base; d_req = 1'b1; end
    else      begin i_we = we; i_addr = base; i_req = 1'b1; end
    t0 = cyc;
  endtask

  initial begin
    int t0, b0, nd, n;
    rst = 1'b1; i_req = 0; d_req = 0; i_we = 0; d_we = 0;
    i_addr = 0; d_addr = 0; i_wdata = 0; d_wdata = 0; mem_ack = 0; mem_rdata = 0;
    fork monitor(); join_none
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk); #2;
    chk("rst_cs", 32'(mem_cs), 0);
    chk("rst_busy", 32'(arb_busy), 0);
    chk("rst_done", 32'({i_done, d_done}), 0);
    chk("rst_addr", mem_addr, 0);

    // D read, zero-wait
    push_burst(1'b1, 1'b0, 32'h100);
    b0 = busy_cnt;
    start(1'b1, 1'b0, 32'h100, t0);
    wait_done(1);
    chk("d_first_cs_lat", 32'(first_cs_cyc - t0), 1);
    chk("d_done_lat", 32'(done_cyc - t0), 32'(LINE_WORDS_DFLT + 1));
    chk("d_busy_cycles", 32'(busy_cnt - b0), 32'(LINE_WORDS_DFLT + 1));
    drop_reqs();

    // I read, two wait states per word
    wait_n = 2;
    push_burst(1'b0, 1'b0, 32'h240);
    start(1'b0, 1'b0, 32'h240, t0);
    wait_done(2);
    chk("i_done_lat", 32'(done_cyc - t0), 32'(3 * LINE_WORDS_DFLT + 1));
    drop_reqs();

    // D write-back, one wait state
    wait_n = 1;
    push_burst(1'b1, 1'b1, 32'h380);
    start(1'b1, 1'b1, 32'h380, t0);
    wait_done(3);
    drop_reqs();
    d_we = 1'b0;

    // Spurious ack in IDLE, then a fresh burst still starts at word 0
    wait_n = 0;
    force_ack = 1'b1;
    repeat (3) @(negedge clk);
    #2 chk("spur_busy", 32'(arb_busy), 0);
    force_ack = 1'b0;
    push_burst(1'b1, 1'b0, 32'h400);
    start(1'b1, 1'b0, 32'h400, t0);
    wait_done(4);
    drop_reqs();

    // Contention from reset; both requests held across bursts
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    nd = 4;
    for (int k = 0; k < nd; k++) push_burst((k % 2) == 0, 1'b0, ((k % 2) == 0) ? 32'h600 : 32'h500);
`else
    nd = 3;
    for (int k = 0; k < nd; k++) push_burst(1'b1, 1'b0, 32'h600);
`endif
    i_addr = 32'h500; d_addr = 32'h600; i_we = 0; d_we = 0;
    i_req = 1'b1; d_req = 1'b1;
    wait_done(4 + nd);
    drop_reqs();
    chk("arb_drained", 32'(exp_q.size()), 0);

    // Reset on the word-2 ack aborts the burst without a done pulse
    push_burst(1'b1, 1'b0, 32'h700);
    start(1'b1, 1'b0, 32'h700, t0);
    n = 0;
    do begin @(negedge clk); #2; n++; end
    while (!(mem_cs && mem_ack && word_idx == IDX_W'(2)) && n < 50);
    chk("rst_word2_seen", 32'(n < 50), 1);
    rst = 1'b1; d_req = 1'b0;
    exp_q.delete(); done_q.delete();
    nd = done_seen;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk); #2;
    chk("abort_cs", 32'(mem_cs), 0);
    chk("abort_busy", 32'(arb_busy), 0);
    chk("abort_d_done", 32'(d_done), 0);
    repeat (3) @(negedge clk);
    chk("abort_no_done", 32'(done_seen), 32'(nd));
    push_burst(1'b1, 1'b0, 32'h800);
    start(1'b1, 1'b0, 32'h800, t0);
    wait_done(nd + 1);
    drop_reqs();
    repeat (3) @(negedge clk);
    chk("final_drained", 32'(exp_q.size() + done_q.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
